// File: rtl/param_alu_regfile.sv
// param_alu_regfile: WIDTH-bit ALU with register file, flag register
// and an iterative shift-add multiplier behind valid/ready handshakes.
module param_alu_regfile #(
  parameter int WIDTH = 8,
  parameter int REGS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int IDX_W = $clog2(REGS);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_PA   = 4'h6;
  localparam logic [3:0] OP_PB   = 4'h7;
  localparam logic [3:0] OP_WR   = 4'h8;
  localparam logic [3:0] OP_RD   = 4'h9;
  localparam logic [3:0] OP_ADDR = 4'hA;
  localparam logic [3:0] OP_SUBR = 4'hB;
  localparam logic [3:0] OP_ADC  = 4'hC;
  localparam logic [3:0] OP_SBC  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_ROL  = 4'hF;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [WIDTH-1:0]     rf_q [REGS];
  logic [WIDTH-1:0]     rf_d [REGS];
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 mul_last;
  logic [IDX_W-1:0]     idx;
  logic [WIDTH-1:0]     rf_rd;
  logic [WIDTH-1:0]     b_eff;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic                 ovf;
  logic [WIDTH-1:0]     rot_amt;
  logic [2*WIDTH-1:0]   rot_full;
  logic [WIDTH-1:0]     alu_res;
  logic                 is_arith;
  logic [2*WIDTH-1:0]   acc_sum;

  assign idx      = b[IDX_W-1:0];
  assign rf_rd    = rf_q[idx];
  assign accept   = in_valid && in_ready;
  assign mul_last = busy && (cnt_q == CNT_W'(WIDTH - 1));

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && op == OP_MUL) state_d = S_MUL;
      S_MUL:  if (mul_last) state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_q == S_MUL);
    in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  end

  // One adder serves every add/subtract form via b_eff and cin
  always_comb begin
    b_eff = b;
    cin   = 1'b0;
    unique case (op)
      OP_SUB:  begin b_eff = ~b;     cin = 1'b1;       end
      OP_ADDR: begin b_eff = rf_rd;                    end
      OP_SUBR: begin b_eff = ~rf_rd; cin = 1'b1;       end
      OP_ADC:  begin                 cin = flags_q[0]; end
      OP_SBC:  begin b_eff = ~b;     cin = flags_q[0]; end
      default: ;
    endcase
  end

  assign sum      = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
  assign ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
  assign rot_amt  = b % WIDTH'(WIDTH);
  assign rot_full = {a, a} << rot_amt;
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res  = sum[WIDTH-1:0];
    is_arith = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_ADDR,
      OP_SUBR, OP_ADC, OP_SBC: is_arith = 1'b1;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_PA:   alu_res = a;
      OP_PB:   alu_res = b;
      OP_WR:   alu_res = a;
      OP_RD:   alu_res = rf_rd;
      OP_ROL:  alu_res = rot_full[2*WIDTH-1:WIDTH];
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    flags_d     = flags_q;
    rf_d        = rf_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      if (op == OP_MUL) begin
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        out_valid_d = 1'b1;
        result_d    = alu_res;
        flags_d     = {alu_res == '0, alu_res[WIDTH-1],
                       is_arith ? {ovf, sum[WIDTH]} : flags_q[1:0]};
        if (op == OP_WR) rf_d[idx] = a;
      end
    end
    if (busy) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      // Output register was empty at accept, so it loads unconditionally
      if (mul_last) begin
        out_valid_d = 1'b1;
        result_d    = acc_sum[WIDTH-1:0];
        flags_d     = {acc_sum[WIDTH-1:0] == '0, acc_sum[WIDTH-1],
                       1'b0, |acc_sum[2*WIDTH-1:WIDTH]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < REGS; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule
